// File: rtl/core_bus_pkg.sv
// Shared types for the core bus arbiter: FSM states, grant encoding and
// the bus request record presented to the memory slave.
package core_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_LSU,
        GNT_DBG
    } grant_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_AW-1:0]     addr;
        logic [BUS_DW/8-1:0]   byte_en;
        logic [BUS_DW-1:0]     wdata;
    } bus_req_t;

endpackage

// File: rtl/core_bus_prio_sel.sv
// Combinational winner selection: debug > LSU > fetch, except that a
// starved fetch request overrides everything.
module core_bus_prio_sel
    import core_bus_pkg::*;
(
    input  logic   fetch_req,
    input  logic   lsu_req,
    input  logic   dbg_req,
    input  logic   starved,
    output grant_t grant
);

    always_comb begin
        grant = GNT_NONE;
        if (starved && fetch_req) begin
            grant = GNT_FETCH;
        end else if (dbg_req) begin
            grant = GNT_DBG;
        end else if (lsu_req) begin
            grant = GNT_LSU;
        end else if (fetch_req) begin
            grant = GNT_FETCH;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares the single memory bus between fetch, LSU and debug with one
// outstanding transaction, a fetch starvation guard and a bus timeout.
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    output logic            o_stall,

    input  logic            i_fetch_read,
    input  logic [AW-1:0]   i_fetch_addr,
    output logic [DW-1:0]   o_fetch_data,
    output logic            o_fetch_ack,

    input  logic            i_lsu_req,
    input  logic            i_lsu_we,
    input  logic [AW-1:0]   i_lsu_addr,
    input  logic [DW/8-1:0] i_lsu_byte_en,
    input  logic [DW-1:0]   i_lsu_wdata,
    output logic [DW-1:0]   o_lsu_rdata,
    output logic            o_lsu_ack,

    input  logic            i_dbg_req,
    input  logic            i_dbg_we,
    input  logic [AW-1:0]   i_dbg_addr,
    input  logic [DW/8-1:0] i_dbg_byte_en,
    input  logic [DW-1:0]   i_dbg_wdata,
    output logic [DW-1:0]   o_dbg_rdata,
    output logic            o_dbg_ack,

    output logic            o_bus_err,

    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW/8-1:0] o_mem_byte_en,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [DW-1:0]   i_mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    arb_state_t    state;
    grant_t        gnt_q;
    grant_t        sel_grant;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          fetch_ack_q;
    logic          lsu_ack_q;
    logic          dbg_ack_q;
    logic          bus_err_q;
    logic          any_req;
    logic          finish;
    logic [DW-1:0] resp_data;

    assign any_req   = i_fetch_read | i_lsu_req | i_dbg_req;
    assign o_stall   = (state != IDLE) | any_req;
    assign finish    = i_mem_ack || (timeout_cnt == TO_LAST);
    assign resp_data = i_mem_ack ? i_mem_rdata : '0;

    // Pulses are only visible in enabled cycles so a frozen RESP never looks like a second ack.
    assign o_fetch_ack = fetch_ack_q & i_clk_en;
    assign o_lsu_ack   = lsu_ack_q & i_clk_en;
    assign o_dbg_ack   = dbg_ack_q & i_clk_en;
    assign o_bus_err   = bus_err_q & i_clk_en;

    core_bus_prio_sel u_prio_sel (
        .fetch_req (i_fetch_read),
        .lsu_req   (i_lsu_req),
        .dbg_req   (i_dbg_req),
        .starved   (starve_cnt == STARVE_MAX),
        .grant     (sel_grant)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            gnt_q         <= GNT_NONE;
            starve_cnt    <= '0;
            timeout_cnt   <= '0;
            fetch_ack_q   <= 1'b0;
            lsu_ack_q     <= 1'b0;
            dbg_ack_q     <= 1'b0;
            bus_err_q     <= 1'b0;
            o_fetch_data  <= '0;
            o_lsu_rdata   <= '0;
            o_dbg_rdata   <= '0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_byte_en <= '0;
            o_mem_wdata   <= '0;
        end else if (i_clk_en) begin
            fetch_ack_q <= 1'b0;
            lsu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    timeout_cnt <= '0;
                    if (!i_fetch_read || sel_grant == GNT_FETCH) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                    if (sel_grant != GNT_NONE) begin
                        gnt_q     <= sel_grant;
                        state     <= WAIT;
                        o_mem_req <= 1'b1;
                        case (sel_grant)
                            GNT_DBG: begin
                                o_mem_we      <= i_dbg_we;
                                o_mem_addr    <= i_dbg_addr;
                                o_mem_byte_en <= i_dbg_we ? i_dbg_byte_en : '1;
                                o_mem_wdata   <= i_dbg_wdata;
                            end
                            GNT_LSU: begin
                                o_mem_we      <= i_lsu_we;
                                o_mem_addr    <= i_lsu_addr;
                                o_mem_byte_en <= i_lsu_we ? i_lsu_byte_en : '1;
                                o_mem_wdata   <= i_lsu_wdata;
                            end
                            default: begin
                                o_mem_we      <= 1'b0;
                                o_mem_addr    <= i_fetch_addr;
                                o_mem_byte_en <= '1;
                                o_mem_wdata   <= '0;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    // A real ack wins over a simultaneous timeout.
                    if (finish) begin
                        o_mem_req <= 1'b0;
                        bus_err_q <= !i_mem_ack;
                        state     <= RESP;
                        case (gnt_q)
                            GNT_FETCH: begin
                                fetch_ack_q  <= 1'b1;
                                o_fetch_data <= resp_data;
                            end
                            GNT_LSU: begin
                                lsu_ack_q   <= 1'b1;
                                o_lsu_rdata <= resp_data;
                            end
                            GNT_DBG: begin
                                dbg_ack_q   <= 1'b1;
                                o_dbg_rdata <= resp_data;
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter (STARVE_LIMIT=4, TIMEOUT=8);
// a small slave task answers bus requests, each test task checks its own scenario.
module tb_core_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_clk_en = 1'b1;
    logic        o_stall;
    logic        i_fetch_read = 1'b0;
    logic [31:0] i_fetch_addr = '0;
    logic [31:0] o_fetch_data;
    logic        o_fetch_ack;
    logic        i_lsu_req = 1'b0;
    logic        i_lsu_we = 1'b0;
    logic [31:0] i_lsu_addr = '0;
    logic [3:0]  i_lsu_byte_en = '0;
    logic [31:0] i_lsu_wdata = '0;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_ack;
    logic        i_dbg_req = 1'b0;
    logic        i_dbg_we = 1'b0;
    logic [31:0] i_dbg_addr = '0;
    logic [3:0]  i_dbg_byte_en = '0;
    logic [31:0] i_dbg_wdata = '0;
    logic [31:0] o_dbg_rdata;
    logic        o_dbg_ack;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_byte_en;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    int cmp_count = 0;
    int err_count = 0;

    always #5 i_clk = ~i_clk;

    core_bus_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .o_stall(o_stall),
        .i_fetch_read(i_fetch_read), .i_fetch_addr(i_fetch_addr),
        .o_fetch_data(o_fetch_data), .o_fetch_ack(o_fetch_ack),
        .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
        .i_lsu_byte_en(i_lsu_byte_en), .i_lsu_wdata(i_lsu_wdata),
        .o_lsu_rdata(o_lsu_rdata), .o_lsu_ack(o_lsu_ack),
        .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
        .i_dbg_byte_en(i_dbg_byte_en), .i_dbg_wdata(i_dbg_wdata),
        .o_dbg_rdata(o_dbg_rdata), .o_dbg_ack(o_dbg_ack),
        .o_bus_err(o_bus_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_byte_en(o_mem_byte_en), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    // At most one port may ever see an ack.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            cmp_count++;
            if (!$onehot0({o_fetch_ack, o_lsu_ack, o_dbg_ack})) begin
                err_count++;
                $display("[TB] FAIL ack_onehot: got %b expected at most one set",
                         {o_fetch_ack, o_lsu_ack, o_dbg_ack});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic wait_mem_req(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (o_mem_req === 1'b1) got = 1'b1;
            else tick();
        end
    endtask

    // Waits for a bus request, records its fields, then acks after 'delay' cycles.
    // Returns at the negedge of the RESP cycle.
    task automatic run_slave(input logic [31:0] rdata, input int delay,
                             output logic got, output logic we, output logic [31:0] addr,
                             output logic [3:0] be, output logic [31:0] wd);
        we = 1'b0; addr = '0; be = '0; wd = '0;
        wait_mem_req(got);
        if (got) begin
            we = o_mem_we; addr = o_mem_addr; be = o_mem_byte_en; wd = o_mem_wdata;
            repeat (delay) tick();
            i_mem_ack = 1'b1;
            i_mem_rdata = rdata;
            tick();
            i_mem_ack = 1'b0;
            i_mem_rdata = '0;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        cmp_count++;
        if ({o_mem_req, o_stall, o_fetch_ack, o_lsu_ack, o_dbg_ack, o_bus_err} !== 6'b0) begin
            err_count++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {o_mem_req, o_stall, o_fetch_ack, o_lsu_ack, o_dbg_ack, o_bus_err});
        end
        cmp_count++;
        if ({o_mem_addr, o_mem_byte_en, o_fetch_data, o_lsu_rdata} !== '0) begin
            err_count++;
            $display("[TB] FAIL reset_data: got addr %h be %h fd %h ld %h expected all 0",
                     o_mem_addr, o_mem_byte_en, o_fetch_data, o_lsu_rdata);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_read();
        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h100;
        #1;
        cmp_count++;
        if (o_stall !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL fetch_stall_req: got %b expected 1", o_stall);
        end
        tick();
        cmp_count++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_byte_en} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
            err_count++;
            $display("[TB] FAIL fetch_bus: got req %b we %b addr %h be %h expected 1 0 00000100 f",
                     o_mem_req, o_mem_we, o_mem_addr, o_mem_byte_en);
        end
        tick();
        cmp_count++;
        if ({o_fetch_ack, o_stall} !== 2'b01) begin
            err_count++;
            $display("[TB] FAIL fetch_wait: got ack %b stall %b expected 0 1", o_fetch_ack, o_stall);
        end
        tick();
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h0000_0013;
        tick();
        i_mem_ack = 1'b0;
        cmp_count++;
        if ({o_fetch_ack, o_fetch_data, o_stall, o_mem_req} !== {1'b1, 32'h13, 1'b1, 1'b0}) begin
            err_count++;
            $display("[TB] FAIL fetch_ack: got ack %b data %h stall %b req %b expected 1 00000013 1 0",
                     o_fetch_ack, o_fetch_data, o_stall, o_mem_req);
        end
        i_fetch_read = 1'b0;
        tick();
        cmp_count++;
        if ({o_fetch_ack, o_fetch_data, o_stall} !== {1'b0, 32'h13, 1'b0}) begin
            err_count++;
            $display("[TB] FAIL fetch_after: got ack %b data %h stall %b expected 0 00000013 0",
                     o_fetch_ack, o_fetch_data, o_stall);
        end
    endtask

    task automatic test_lsu_vs_fetch();
        logic got, we;
        logic [31:0] addr, wd;
        logic [3:0] be;
        i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h200;
        i_lsu_byte_en = 4'b0011; i_lsu_wdata = 32'hA5A5;
        i_fetch_read = 1'b1; i_fetch_addr = 32'h104;
        run_slave(32'hDEAD_0001, 1, got, we, addr, be, wd);
        cmp_count++;
        if ({got, we, addr, be, wd} !== {1'b1, 1'b1, 32'h200, 4'b0011, 32'hA5A5}) begin
            err_count++;
            $display("[TB] FAIL lsu_write_bus: got %b %b %h %b %h expected 1 1 00000200 0011 0000a5a5",
                     got, we, addr, be, wd);
        end
        cmp_count++;
        if ({o_lsu_ack, o_fetch_ack} !== 2'b10) begin
            err_count++;
            $display("[TB] FAIL lsu_first_ack: got lsu %b fetch %b expected 1 0", o_lsu_ack, o_fetch_ack);
        end
        i_lsu_req = 1'b0;
        run_slave(32'h0000_0077, 0, got, we, addr, be, wd);
        cmp_count++;
        if ({got, we, addr, be} !== {1'b1, 1'b0, 32'h104, 4'hF}) begin
            err_count++;
            $display("[TB] FAIL fetch_second_bus: got %b %b %h %b expected 1 0 00000104 1111",
                     got, we, addr, be);
        end
        cmp_count++;
        if ({o_fetch_ack, o_lsu_ack, o_fetch_data} !== {1'b1, 1'b0, 32'h77}) begin
            err_count++;
            $display("[TB] FAIL fetch_second_ack: got %b %b %h expected 1 0 00000077",
                     o_fetch_ack, o_lsu_ack, o_fetch_data);
        end
        i_fetch_read = 1'b0;
        tick();
    endtask

    task automatic test_three_way();
        logic got, we;
        logic [31:0] addr, wd;
        logic [3:0] be;
        logic [31:0] exp_addr [3];
        logic [2:0] exp_acks [3];
        exp_addr = '{32'h300, 32'h204, 32'h108};
        exp_acks = '{3'b001, 3'b010, 3'b100};
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 32'h300; i_dbg_byte_en = 4'b0101;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h204; i_lsu_byte_en = 4'b0001;
        i_fetch_read = 1'b1; i_fetch_addr = 32'h108;
        for (int k = 0; k < 3; k++) begin
            run_slave(32'hB000_0000 + 32'(k), 0, got, we, addr, be, wd);
            cmp_count++;
            if ({got, addr, be} !== {1'b1, exp_addr[k], 4'hF}) begin
                err_count++;
                $display("[TB] FAIL three_way_bus[%0d]: got %b %h %b expected 1 %h 1111",
                         k, got, addr, be, exp_addr[k]);
            end
            cmp_count++;
            if ({o_fetch_ack, o_lsu_ack, o_dbg_ack} !== exp_acks[k]) begin
                err_count++;
                $display("[TB] FAIL three_way_ack[%0d]: got %b expected %b",
                         k, {o_fetch_ack, o_lsu_ack, o_dbg_ack}, exp_acks[k]);
            end
            if (k == 0) i_dbg_req = 1'b0;
            if (k == 1) i_lsu_req = 1'b0;
            if (k == 2) i_fetch_read = 1'b0;
        end
        cmp_count++;
        if ({o_dbg_rdata, o_lsu_rdata, o_fetch_data} !== {32'hB000_0000, 32'hB000_0001, 32'hB000_0002}) begin
            err_count++;
            $display("[TB] FAIL three_way_data: got %h %h %h expected b0000000 b0000001 b0000002",
                     o_dbg_rdata, o_lsu_rdata, o_fetch_data);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic got, we;
        logic [31:0] addr, wd;
        logic [3:0] be;
        logic [31:0] exp;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h208;
        i_fetch_read = 1'b1; i_fetch_addr = 32'h10C;
        for (int k = 1; k <= 6; k++) begin
            run_slave(32'h1000 + 32'(k), 0, got, we, addr, be, wd);
            exp = (k == 5) ? 32'h10C : 32'h208;
            cmp_count++;
            if ({got, addr} !== {1'b1, exp}) begin
                err_count++;
                $display("[TB] FAIL starve_round[%0d]: got %b %h expected 1 %h", k, got, addr, exp);
            end
            cmp_count++;
            if ({o_fetch_ack, o_lsu_ack} !== ((k == 5) ? 2'b10 : 2'b01)) begin
                err_count++;
                $display("[TB] FAIL starve_ack[%0d]: got fetch %b lsu %b", k, o_fetch_ack, o_lsu_ack);
            end
        end
        i_lsu_req = 1'b0;
        run_slave(32'h2000, 0, got, we, addr, be, wd);
        cmp_count++;
        if ({got, addr, o_fetch_ack} !== {1'b1, 32'h10C, 1'b1}) begin
            err_count++;
            $display("[TB] FAIL starve_drain: got %b %h ack %b expected 1 0000010c 1", got, addr, o_fetch_ack);
        end
        i_fetch_read = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic got;
        int n;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h210; i_lsu_byte_en = 4'h0;
        wait_mem_req(got);
        cmp_count++;
        if ({got, o_mem_byte_en} !== {1'b1, 4'hF}) begin
            err_count++;
            $display("[TB] FAIL timeout_req: got %b be %b expected 1 1111", got, o_mem_byte_en);
        end
        n = 0;
        while (o_mem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        cmp_count++;
        if (n != 8) begin
            err_count++;
            $display("[TB] FAIL timeout_cycles: got %0d expected 8", n);
        end
        cmp_count++;
        if ({o_lsu_ack, o_bus_err, o_lsu_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            err_count++;
            $display("[TB] FAIL timeout_resp: got ack %b err %b data %h expected 1 1 00000000",
                     o_lsu_ack, o_bus_err, o_lsu_rdata);
        end
        i_lsu_req = 1'b0;
        tick();
        cmp_count++;
        if ({o_lsu_ack, o_bus_err} !== 2'b00) begin
            err_count++;
            $display("[TB] FAIL timeout_after: got ack %b err %b expected 0 0", o_lsu_ack, o_bus_err);
        end
    endtask

    task automatic test_async_reset();
        logic got, we;
        logic [31:0] addr, wd;
        logic [3:0] be;
        i_fetch_read = 1'b1; i_fetch_addr = 32'h120;
        wait_mem_req(got);
        tick();
        #2;
        i_rst = 1'b1;
        #1;
        cmp_count++;
        if ({got, o_mem_req} !== 2'b10) begin
            err_count++;
            $display("[TB] FAIL async_reset_req: got seen %b req %b expected 1 0", got, o_mem_req);
        end
        i_fetch_read = 1'b0;
        tick();
        tick();
        cmp_count++;
        if ({o_fetch_ack, o_stall} !== 2'b00) begin
            err_count++;
            $display("[TB] FAIL async_reset_ack: got ack %b stall %b expected 0 0", o_fetch_ack, o_stall);
        end
        i_rst = 1'b0;
        tick();
        i_fetch_read = 1'b1; i_fetch_addr = 32'h124;
        run_slave(32'h5555_0001, 1, got, we, addr, be, wd);
        cmp_count++;
        if ({got, addr, o_fetch_ack, o_fetch_data} !== {1'b1, 32'h124, 1'b1, 32'h5555_0001}) begin
            err_count++;
            $display("[TB] FAIL async_reset_fresh: got %b %h ack %b data %h expected 1 00000124 1 55550001",
                     got, addr, o_fetch_ack, o_fetch_data);
        end
        i_fetch_read = 1'b0;
        tick();
    endtask

    task automatic test_clock_enable();
        logic got;
        i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h220;
        i_lsu_byte_en = 4'hF; i_lsu_wdata = 32'h1234_5678;
        wait_mem_req(got);
        cmp_count++;
        if ({got, o_mem_we, o_mem_wdata} !== {1'b1, 1'b1, 32'h1234_5678}) begin
            err_count++;
            $display("[TB] FAIL clken_bus: got %b we %b wd %h expected 1 1 12345678", got, o_mem_we, o_mem_wdata);
        end
        i_clk_en = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp_count++;
            if ({o_lsu_ack, o_mem_req} !== 2'b01) begin
                err_count++;
                $display("[TB] FAIL clken_frozen[%0d]: got ack %b req %b expected 0 1", k, o_lsu_ack, o_mem_req);
            end
        end
        i_clk_en = 1'b1;
        tick();
        cmp_count++;
        if ({o_lsu_ack, o_lsu_rdata, o_mem_req, o_bus_err} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b0}) begin
            err_count++;
            $display("[TB] FAIL clken_ack: got ack %b data %h req %b err %b expected 1 cafef00d 0 0",
                     o_lsu_ack, o_lsu_rdata, o_mem_req, o_bus_err);
        end
        i_mem_ack = 1'b0;
        i_lsu_req = 1'b0;
        tick();
        cmp_count++;
        if (o_lsu_ack !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL clken_after: got ack %b expected 0", o_lsu_ack);
        end
    endtask

    initial begin
        $display("[TB] starting core_bus_arbiter tests");
        test_reset();
        test_fetch_read();
        test_lsu_vs_fetch();
        test_three_way();
        test_starvation();
        test_timeout();
        test_async_reset();
        test_clock_enable();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares the core's single memory bus between three requesters: instruction fetch, load/store unit and debug.
- Sits between the fetch/LSU/debug ports and the memory/bus slave, and drives the core-wide stall line.
- Fixed priority is debug > LSU > fetch, with a starvation guard that forces a fetch grant after repeated denials.
- Single outstanding transaction, with a bus-timeout error path.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive denied arbitration rounds before fetch is forced to win
TIMEOUT, 255, cycles in WAIT before the transaction is aborted with error

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_clk_en  in  1  global clock enable; all state frozen when low
o_stall  out  1  high while a transaction is in flight or a request is pending
i_fetch_read  in  1  fetch read request (level, held until ack)
i_fetch_addr  in  AW  fetch address
o_fetch_data  out  DW  fetch read data
o_fetch_ack  out  1  one-cycle fetch completion
i_lsu_req  in  1  LSU request (level, held until ack)
i_lsu_we  in  1  1=write, 0=read
i_lsu_addr  in  AW  LSU address
i_lsu_byte_en  in  DW/8  LSU byte enables (writes)
i_lsu_wdata  in  DW  LSU write data
o_lsu_rdata  out  DW  LSU read data
o_lsu_ack  out  1  one-cycle LSU completion
i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_byte_en, i_dbg_wdata  in  1/1/AW/DW/8/DW  debug port, same semantics as LSU
o_dbg_rdata  out  DW  debug read data
o_dbg_ack  out  1  one-cycle debug completion
o_bus_err  out  1  one-cycle pulse alongside the ack of a timed-out transaction
o_mem_req  out  1  bus request, held until i_mem_ack
o_mem_we  out  1  bus write
o_mem_addr  out  AW  bus address
o_mem_byte_en  out  DW/8  bus byte enables (all ones for reads)
o_mem_wdata  out  DW  bus write data
i_mem_ack  in  1  bus completion; i_mem_rdata valid in the same cycle
i_mem_rdata  in  DW  bus read data

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; timeout counter 0.
- Reset is asynchronous: asserting it mid-transaction immediately drops o_mem_req, returns to IDLE and issues no ack.
- When i_clk_en is low, state, counters and all registered outputs hold their values. Acks are not re-pulsed: an ack is a registered pulse gated by the cycle's enable.
- State IDLE:
  - If any request is present, pick the winner and latch its addr/we/byte_en/wdata into the bus registers; go to WAIT.
  - o_mem_req rises the next enabled cycle.
- Winner selection: debug > LSU > fetch. If the starvation counter equals STARVE_LIMIT and i_fetch_read is set, fetch wins.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each arbitration where fetch requested and lost.
  - Clears when fetch is granted or is not requesting.
- State WAIT:
  - o_mem_req stays high and the bus fields stay stable.
  - The timeout counter increments each enabled cycle.
  - On i_mem_ack, capture i_mem_rdata and go to RESP.
  - If the counter reaches TIMEOUT with no ack, drop o_mem_req, set rdata to 0, set the error flag and go to RESP.
  - An i_mem_ack arriving in the same cycle as the timeout takes precedence: no error.
- State RESP:
  - Pulse the granted port's ack for one cycle with its data bus valid, plus o_bus_err if flagged.
  - Return to IDLE. Arbitration restarts in the next cycle, so one idle cycle separates back-to-back transactions.
- Ack latency: grant in cycle N, o_mem_req high from N+1, i_mem_ack in cycle M ≥ N+1, port ack in M+1.
- Read data ports hold their last value between acks. Write acks also drive rdata with the captured bus data, which is don't-care.
- o_stall is combinational: (state != IDLE) | any request input high.
- A requester dropping its request mid-transaction is illegal. The transaction still completes and the ack is still pulsed.
- Only the granted port's ack is ever asserted: acks are one-hot or zero.

Decomposition:
- Package core_bus_pkg holds:
  - typedef enum {IDLE, WAIT, RESP} arb_state_t
  - typedef enum {GNT_NONE, GNT_FETCH, GNT_LSU, GNT_DBG} grant_t
  - a struct bus_req_t {we, addr, byte_en, wdata}
- One sub-module is natural: core_bus_prio_sel, a combinational priority/starvation select that takes the three requests and the starvation flag and returns grant_t.

Test Plan:
- Fetch only, addr 0x100, slave acks 2 cycles after o_mem_req with 0x00000013 -> o_fetch_ack pulses once with o_fetch_data=0x00000013; o_stall high from the request until the ack cycle.
- LSU write 0x200, byte_en 4'b0011, wdata 0xA5A5 concurrent with fetch read -> LSU granted first, bus sees we=1, byte_en=0011; fetch granted next and completes; acks are never simultaneous.
- Debug, LSU and fetch asserted together -> grant order debug, LSU, fetch.
- LSU held continuously with fetch pending and STARVE_LIMIT=4 -> fetch granted on the 5th arbitration.
- Slave never acks, TIMEOUT=8 -> o_mem_req drops after 8 WAIT cycles; o_lsu_ack and o_bus_err pulse together with rdata 0.
- i_rst asserted in WAIT -> o_mem_req low asynchronously; no ack; after release a fresh request completes normally.
- i_clk_en low for 3 cycles during WAIT with i_mem_ack held -> no progress while low; the ack is captured on the first enabled cycle.
